// File: rtl/ag_tcu_wmma_uop_sequencer_pkg.sv
// Shared definitions for the AG-TCU WMMA micro-op sequencer: tile geometry,
// format encodings, format-pair legality and the micro-op record.
package ag_tcu_wmma_uop_sequencer_pkg;

    localparam int unsigned STEP_W = 4;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [3:0] {
        FMT_FP32 = 4'd0,
        FMT_FP16 = 4'd1,
        FMT_BF16 = 4'd2,
        FMT_I32  = 4'd8,
        FMT_I8   = 4'd9,
        FMT_U8   = 4'd10,
        FMT_I4   = 4'd11,
        FMT_U4   = 4'd12
    } fmt_e;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } seq_state_e;

    typedef struct packed {
        logic [STEP_W-1:0] step_m;
        logic [STEP_W-1:0] step_n;
        logic [STEP_W-1:0] step_k;
        logic [REG_W-1:0]  ra;
        logic [REG_W-1:0]  rb;
        logic [REG_W-1:0]  rc;
        logic              first;
        logic              last;
    } ag_tcu_uop_t;

    // Core block is TC_M x TC_N threads; the square tile splits into steps of that block.
    function automatic int unsigned calc_tc_n(int unsigned nt);
        return 32'd1 << ($clog2(nt) / 2);
    endfunction

    function automatic int unsigned calc_tc_m(int unsigned nt);
        return nt / calc_tc_n(nt);
    endfunction

    function automatic int unsigned calc_tc_k(int unsigned nt, int unsigned dp);
        return (dp != 0) ? dp : nt / calc_tc_m(nt);
    endfunction

    function automatic int unsigned calc_tile_mn(int unsigned nt, int unsigned nr);
        return 32'd1 << ($clog2(nt * nr) / 2);
    endfunction

    function automatic int unsigned calc_tile_k(int unsigned nt, int unsigned nr);
        return (nt * nr) / calc_tile_mn(nt, nr);
    endfunction

    function automatic int unsigned calc_m_steps(int unsigned nt, int unsigned nr);
        return calc_tile_mn(nt, nr) / calc_tc_m(nt);
    endfunction

    function automatic int unsigned calc_n_steps(int unsigned nt, int unsigned nr);
        return calc_tile_mn(nt, nr) / calc_tc_n(nt);
    endfunction

    function automatic int unsigned calc_k_steps(int unsigned nt, int unsigned nr, int unsigned dp);
        return calc_tile_k(nt, nr) / calc_tc_k(nt, dp);
    endfunction

    function automatic int unsigned calc_nrb(int unsigned nt, int unsigned nr);
        return (calc_tile_mn(nt, nr) * calc_tile_k(nt, nr)) / nt;
    endfunction

    function automatic int unsigned calc_rb_base(int unsigned nrb);
        return (nrb == 4) ? 28 : 10;
    endfunction

    function automatic int unsigned calc_rc_base(int unsigned nrb);
        return (nrb == 4) ? 10 : 24;
    endfunction

    function automatic int unsigned step_width(int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic logic fmt_legal(logic [3:0] fmt_s, logic [3:0] fmt_d);
        logic float_s, float_d, int_s;
        float_s = (fmt_s == FMT_FP32) || (fmt_s == FMT_FP16) || (fmt_s == FMT_BF16);
        float_d = (fmt_d == FMT_FP32) || (fmt_d == FMT_FP16) || (fmt_d == FMT_BF16);
        int_s   = (fmt_s == FMT_I8) || (fmt_s == FMT_U8) || (fmt_s == FMT_I4) || (fmt_s == FMT_U4);
        return (float_s && float_d) || (int_s && (fmt_d == FMT_I32));
    endfunction

    function automatic ag_tcu_uop_t make_uop(
        logic [STEP_W-1:0] m, logic [STEP_W-1:0] n, logic [STEP_W-1:0] k,
        int unsigned m_steps, int unsigned n_steps, int unsigned k_steps,
        int unsigned ra_base, int unsigned rb_base, int unsigned rc_base
    );
        ag_tcu_uop_t u;
        u.step_m = m;
        u.step_n = n;
        u.step_k = k;
        u.ra     = REG_W'(ra_base + 32'(m) * k_steps + 32'(k));
        u.rb     = REG_W'(rb_base + 32'(n) * k_steps + 32'(k));
        u.rc     = REG_W'(rc_base + 32'(m) * n_steps + 32'(n));
        u.first  = (m == '0) && (n == '0) && (k == '0);
        u.last   = (32'(m) == m_steps - 1) && (32'(n) == n_steps - 1) && (32'(k) == k_steps - 1);
        return u;
    endfunction

endpackage

// File: rtl/ag_tcu_step_counter.sv
// Three-level mixed-radix step counter (K innermost, then N, then M) holding
// the index of the micro-op currently presented; exposes the next index.
module ag_tcu_step_counter
    import ag_tcu_wmma_uop_sequencer_pkg::*;
#(
    parameter int unsigned M_STEPS = 2,
    parameter int unsigned N_STEPS = 4,
    parameter int unsigned K_STEPS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [STEP_W-1:0] nxt_m,
    output logic [STEP_W-1:0] nxt_n,
    output logic [STEP_W-1:0] nxt_k,
    output logic              last,
    output logic              wrap
);

    logic [STEP_W-1:0] cnt_m, cnt_n, cnt_k;
    logic              m_max, n_max, k_max;

    assign m_max = (cnt_m == STEP_W'(M_STEPS - 1));
    assign n_max = (cnt_n == STEP_W'(N_STEPS - 1));
    assign k_max = (cnt_k == STEP_W'(K_STEPS - 1));
    assign last  = m_max && n_max && k_max;
    assign wrap  = inc && last;

    always_comb begin
        nxt_k = k_max ? '0 : cnt_k + STEP_W'(1);
        nxt_n = cnt_n;
        nxt_m = cnt_m;
        if (k_max) begin
            nxt_n = n_max ? '0 : cnt_n + STEP_W'(1);
            if (n_max) begin
                nxt_m = m_max ? '0 : cnt_m + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_m <= '0;
            cnt_n <= '0;
            cnt_k <= '0;
        end else if (clear) begin
            cnt_m <= '0;
            cnt_n <= '0;
            cnt_k <= '0;
        end else if (inc) begin
            cnt_m <= nxt_m;
            cnt_n <= nxt_n;
            cnt_k <= nxt_k;
        end
    end

endmodule

// File: rtl/ag_tcu_wmma_uop_sequencer.sv
// Expands one WMMA instruction into M_STEPS*N_STEPS*K_STEPS registered micro-ops,
// with format checking, flush and zero-bubble chaining of back-to-back instructions.
module ag_tcu_wmma_uop_sequencer
    import ag_tcu_wmma_uop_sequencer_pkg::*;
#(
    parameter int unsigned NT      = 8,
    parameter int unsigned NR      = 8,
    parameter int unsigned DP      = 0,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned RA_BASE = 0,
    localparam int unsigned M_STEPS = calc_m_steps(NT, NR),
    localparam int unsigned N_STEPS = calc_n_steps(NT, NR),
    localparam int unsigned K_STEPS = calc_k_steps(NT, NR, DP),
    localparam int unsigned MW      = step_width(M_STEPS),
    localparam int unsigned NW      = step_width(N_STEPS),
    localparam int unsigned KW      = step_width(K_STEPS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [3:0]       in_fmt_s,
    input  logic [3:0]       in_fmt_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_fmt_s,
    output logic [3:0]       out_fmt_d,
    output logic [MW-1:0]    out_step_m,
    output logic [NW-1:0]    out_step_n,
    output logic [KW-1:0]    out_step_k,
    output logic [4:0]       out_ra,
    output logic [4:0]       out_rb,
    output logic [4:0]       out_rc,
    output logic             out_first,
    output logic             out_last,
    output logic             fmt_err,
    output logic             busy
);

    localparam int unsigned NRB     = calc_nrb(NT, NR);
    localparam int unsigned RB_BASE = calc_rb_base(NRB);
    localparam int unsigned RC_BASE = calc_rc_base(NRB);
    localparam int unsigned RA_MAX  = RA_BASE + M_STEPS * K_STEPS - 1;
    localparam int unsigned RB_MAX  = RB_BASE + N_STEPS * K_STEPS - 1;
    localparam int unsigned RC_MAX  = RC_BASE + M_STEPS * N_STEPS - 1;

    if (RA_MAX > 31 || RB_MAX > 31 || RC_MAX > 31 ||
        M_STEPS > (1 << STEP_W) || N_STEPS > (1 << STEP_W) || K_STEPS > (1 << STEP_W)) begin : g_geom_check
        $error("ag_tcu_wmma_uop_sequencer: register index or step count out of range");
    end

    seq_state_e        state;
    ag_tcu_uop_t       uop_q;
    logic              accept, hs;
    logic              cnt_inc, cnt_clear, cnt_last, cnt_wrap;
    logic [STEP_W-1:0] nxt_m, nxt_n, nxt_k;
    logic              unused_step_hi;

    // In ISSUE the counter sits on the presented uop, so cnt_last mirrors out_last.
    assign in_ready  = !flush && ((state == ST_IDLE) || (cnt_last && out_ready));
    assign accept    = in_valid && in_ready;
    assign hs        = out_valid && out_ready;
    assign cnt_inc   = hs && !flush;
    assign cnt_clear = accept || flush;

    ag_tcu_step_counter #(
        .M_STEPS(M_STEPS),
        .N_STEPS(N_STEPS),
        .K_STEPS(K_STEPS)
    ) u_step_counter (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .nxt_m(nxt_m),
        .nxt_n(nxt_n),
        .nxt_k(nxt_k),
        .last (cnt_last),
        .wrap (cnt_wrap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            fmt_err   <= 1'b0;
            out_tag   <= '0;
            out_fmt_s <= '0;
            out_fmt_d <= '0;
            uop_q     <= '0;
        end else begin
            fmt_err <= 1'b0;
            if (flush) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else if (accept) begin
                out_tag   <= in_tag;
                out_fmt_s <= in_fmt_s;
                out_fmt_d <= in_fmt_d;
                if (fmt_legal(in_fmt_s, in_fmt_d)) begin
                    state     <= ST_ISSUE;
                    out_valid <= 1'b1;
                    busy      <= 1'b1;
                    uop_q     <= make_uop('0, '0, '0, M_STEPS, N_STEPS, K_STEPS,
                                          RA_BASE, RB_BASE, RC_BASE);
                end else begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    fmt_err   <= 1'b1;
                end
            end else if (cnt_wrap) begin
                state     <= ST_IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else if (hs) begin
                uop_q <= make_uop(nxt_m, nxt_n, nxt_k, M_STEPS, N_STEPS, K_STEPS,
                                  RA_BASE, RB_BASE, RC_BASE);
            end
        end
    end

    assign out_step_m = uop_q.step_m[MW-1:0];
    assign out_step_n = uop_q.step_n[NW-1:0];
    assign out_step_k = uop_q.step_k[KW-1:0];
    assign out_ra     = uop_q.ra;
    assign out_rb     = uop_q.rb;
    assign out_rc     = uop_q.rc;
    assign out_first  = uop_q.first;
    assign out_last   = uop_q.last;

    assign unused_step_hi = ^{uop_q.step_m, uop_q.step_n, uop_q.step_k};

endmodule

// File: tb/tb_ag_tcu_wmma_uop_sequencer.sv
// Directed bench for the WMMA micro-op sequencer: a queue-based model of the
// expected micro-op stream is compared against the DUT on every cycle.
module tb_ag_tcu_wmma_uop_sequencer;
    import ag_tcu_wmma_uop_sequencer_pkg::*;

    localparam int TB_M = 2, TB_N = 4, TB_K = 4, TB_UOPS = 32;
    localparam int TB_RA = 0, TB_RB = 10, TB_RC = 24;

    logic       clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_tag, out_tag;
    logic [3:0] in_fmt_s, in_fmt_d, out_fmt_s, out_fmt_d;
    logic [0:0] out_step_m;
    logic [1:0] out_step_n, out_step_k;
    logic [4:0] out_ra, out_rb, out_rc;
    logic       out_first, out_last, fmt_err, busy;

    ag_tcu_wmma_uop_sequencer #(
        .NT(8), .NR(8), .DP(0), .TAG_W(8), .RA_BASE(0)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d),
        .out_step_m(out_step_m), .out_step_n(out_step_n), .out_step_k(out_step_k),
        .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
        .out_first(out_first), .out_last(out_last),
        .fmt_err(fmt_err), .busy(busy)
    );

    typedef struct {
        int tag, fs, fd, m, n, k, ra, rb, rc;
        bit first, last;
    } exp_t;

    typedef struct {
        int tag, m, n, k, ra, rb, rc, cyc;
        bit first, last;
    } log_t;

    exp_t q[$];
    log_t lg[$];
    bit   exp_err;
    int   checks, failures, cyc, acc_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit tb_legal(logic [3:0] s, logic [3:0] d);
        bit sf, df, si;
        sf = s inside {FMT_FP32, FMT_FP16, FMT_BF16};
        df = d inside {FMT_FP32, FMT_FP16, FMT_BF16};
        si = s inside {FMT_I8, FMT_U8, FMT_I4, FMT_U4};
        return (sf && df) || (si && d == FMT_I32);
    endfunction

    function automatic void push_instr(logic [7:0] t, logic [3:0] s, logic [3:0] d);
        for (int i = 0; i < TB_UOPS; i++) begin
            exp_t e;
            e.tag = t; e.fs = s; e.fd = d;
            e.m = i / (TB_N * TB_K);
            e.n = (i / TB_K) % TB_N;
            e.k = i % TB_K;
            e.ra = TB_RA + e.m * TB_K + e.k;
            e.rb = TB_RB + e.n * TB_K + e.k;
            e.rc = TB_RC + e.m * TB_N + e.n;
            e.first = (i == 0);
            e.last = (i == TB_UOPS - 1);
            q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin : cmp
        exp_t e;
        bit rdy, hs, acc;
        if (!reset) begin
            q.delete();
            exp_err = 1'b0;
        end
        rdy = !flush && (q.size() == 0 || (q[0].last && out_ready));
        chk("out_valid", out_valid, q.size() != 0);
        chk("busy", busy, q.size() != 0);
        chk("fmt_err", fmt_err, exp_err);
        chk("in_ready", in_ready, rdy);
        if (q.size() != 0) begin
            e = q[0];
            chk("out_tag", out_tag, e.tag);
            chk("out_fmt_s", out_fmt_s, e.fs);
            chk("out_fmt_d", out_fmt_d, e.fd);
            chk("out_step_m", out_step_m, e.m);
            chk("out_step_n", out_step_n, e.n);
            chk("out_step_k", out_step_k, e.k);
            chk("out_ra", out_ra, e.ra);
            chk("out_rb", out_rb, e.rb);
            chk("out_rc", out_rc, e.rc);
            chk("out_first", out_first, e.first);
            chk("out_last", out_last, e.last);
        end
        if (reset) begin
            hs  = (q.size() != 0) && out_ready && !flush;
            acc = in_valid && rdy;
            if (hs) begin
                lg.push_back('{tag: out_tag, m: out_step_m, n: out_step_n, k: out_step_k,
                               ra: out_ra, rb: out_rb, rc: out_rc, cyc: cyc,
                               first: out_first, last: out_last});
                void'(q.pop_front());
            end
            exp_err = 1'b0;
            if (flush) q.delete();
            else if (acc) begin
                if (tb_legal(in_fmt_s, in_fmt_d)) push_instr(in_tag, in_fmt_s, in_fmt_d);
                else exp_err = 1'b1;
            end
        end
    end

    task automatic present(input logic [7:0] t, input logic [3:0] s, input logic [3:0] d);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_tag = t; in_fmt_s = s; in_fmt_d = d;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) begin
            failures++;
            $display("FAIL accept_timeout: tag %0h never accepted", t);
        end
        acc_cyc = cyc;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d uops outstanding", q.size());
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    task automatic wait_log(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (lg.size() < target && n < 300);
        if (lg.size() < target) begin
            failures++;
            $display("FAIL log_timeout: got %0d uops expected %0d", lg.size(), target);
        end
    endtask

    initial begin
        int base, base2;
        checks = 0; failures = 0; cyc = 0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_tag = '0; in_fmt_s = '0; in_fmt_d = '0;

        @(negedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_rb", out_rb, 0);
        chk("rst_out_rc", out_rc, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // 1: fp16->fp32, no stalls
        base = lg.size();
        present(8'h01, FMT_FP16, FMT_FP32);
        idle();
        drain(1'b0, 200);
        chk("t1_count", lg.size() - base, 32);
        if (lg.size() >= base + 32) begin
            chk("t1_u0_cyc", lg[base].cyc, acc_cyc + 1);
            chk("t1_u0_mnk", {lg[base].m[7:0], lg[base].n[7:0], lg[base].k[7:0]}, 24'h000000);
            chk("t1_u0_ra", lg[base].ra, 0);
            chk("t1_u0_rb", lg[base].rb, 10);
            chk("t1_u0_rc", lg[base].rc, 24);
            chk("t1_u0_first", lg[base].first, 1);
            chk("t1_u5_mnk", {lg[base+5].m[7:0], lg[base+5].n[7:0], lg[base+5].k[7:0]}, 24'h000101);
            chk("t1_u5_regs", {lg[base+5].ra[7:0], lg[base+5].rb[7:0], lg[base+5].rc[7:0]}, {8'd1, 8'd15, 8'd25});
            chk("t1_u31_mnk", {lg[base+31].m[7:0], lg[base+31].n[7:0], lg[base+31].k[7:0]}, 24'h010303);
            chk("t1_u31_regs", {lg[base+31].ra[7:0], lg[base+31].rb[7:0], lg[base+31].rc[7:0]}, {8'd7, 8'd25, 8'd31});
            chk("t1_u31_last", lg[base+31].last, 1);
            chk("t1_span", lg[base+31].cyc - lg[base].cyc, 31);
        end

        // 2: random out_ready stalls
        base = lg.size();
        present(8'h02, FMT_BF16, FMT_FP16);
        idle();
        drain(1'b1, 400);
        chk("t2_count", lg.size() - base, 32);

        // 3: two chained i8->i32 instructions
        out_ready = 1'b1;
        base = lg.size();
        present(8'h11, FMT_I8, FMT_I32);
        present(8'h22, FMT_I8, FMT_I32);
        idle();
        drain(1'b0, 300);
        chk("t3_count", lg.size() - base, 64);
        if (lg.size() >= base + 64) begin
            chk("t3_tag31", lg[base+31].tag, 8'h11);
            chk("t3_tag32", lg[base+32].tag, 8'h22);
            chk("t3_first32", lg[base+32].first, 1);
            chk("t3_span", lg[base+63].cyc - lg[base].cyc, 63);
        end

        // 4: illegal format pair
        base = lg.size();
        present(8'h44, FMT_I8, FMT_FP32);
        idle();
        @(negedge clk); #1;
        chk("t4_fmt_err", fmt_err, 1);
        chk("t4_no_valid", out_valid, 0);
        @(negedge clk); #1;
        chk("t4_err_gone", fmt_err, 0);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_count", lg.size() - base, 0);

        // 5: flush at uop10 with a new instruction waiting
        base = lg.size();
        present(8'h33, FMT_FP32, FMT_FP32);
        idle();
        wait_log(base + 10);
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_tag = 8'h55; in_fmt_s = FMT_FP16; in_fmt_d = FMT_FP16;
        @(negedge clk); #1;
        chk("t5_flush_rdy", in_ready, 0);
        chk("t5_u10_k", out_step_k, 2);
        chk("t5_u10_rc", out_rc, 26);
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        @(negedge clk); #1;
        chk("t5_post_valid", out_valid, 0);
        chk("t5_post_rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("t5_restart_valid", out_valid, 1);
        chk("t5_restart_first", out_first, 1);
        chk("t5_restart_mnk", {out_step_m, out_step_n, out_step_k}, 0);
        chk("t5_restart_tag", out_tag, 8'h55);
        drain(1'b0, 200);
        chk("t5_count", lg.size() - base, 42);

        // 6: asynchronous reset mid-instruction
        base = lg.size();
        present(8'h66, FMT_I4, FMT_I32);
        idle();
        wait_log(base + 20);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_tag", out_tag, 0);
        chk("t6_ra", out_ra, 0);
        chk("t6_last", out_last, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("t6_quiet", out_valid, 0);
        end
        base2 = lg.size();
        present(8'h77, FMT_U8, FMT_I32);
        idle();
        drain(1'b0, 200);
        chk("t6_count", lg.size() - base2, 32);
        if (lg.size() >= base2 + 32) begin
            chk("t6_first", lg[base2].first, 1);
            chk("t6_tag_new", lg[base2].tag, 8'h77);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
